// File: rtl/ram_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_reader_pkg
// Description : Shared definitions for the RAM stream reader. It holds the
//               FSM state encoding and a helper that sizes the word-count
//               field. The count is one bit wider than the address so that
//               it can express a full-depth burst.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The word count ranges over 0..2**addr_width, so it needs one extra bit.
  function automatic int len_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage : ram_stream_reader_pkg
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_reader
// Description : Read-side master for a dual-port RAM with an asynchronous
//               read port. A start command walks a contiguous address range
//               that wraps at the RAM depth. Each word is streamed out on a
//               valid/ready interface, and done pulses at the end.
// Ports       : clk, rst        - clock, async active-high reset
//               start           - command pulse (only honoured in IDLE)
//               base_addr, len  - first address / word count, taken with start
//               busy            - high while a command is in progress
//               ram_addr        - RAM read address
//               ram_dout        - RAM read data (combinational from ram_addr)
//               m_valid, m_ready, m_data, m_last - output stream
//               done            - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int RAM_WIDTH      = 8,
  parameter int RAM_ADDR_WIDTH = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [RAM_ADDR_WIDTH-1:0]             base_addr,
  input  logic [len_width(RAM_ADDR_WIDTH)-1:0]  len,
  output logic                                  busy,
  output logic [RAM_ADDR_WIDTH-1:0]             ram_addr,
  input  logic [RAM_WIDTH-1:0]                  ram_dout,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [RAM_WIDTH-1:0]                  m_data,
  output logic                                  m_last,
  output logic                                  done
);

  localparam int c_LEN_W = len_width(RAM_ADDR_WIDTH);

  state_t                      r_state;
  state_t                      w_state_next;
  logic [RAM_ADDR_WIDTH-1:0]   r_ptr;
  logic [c_LEN_W-1:0]          r_remaining;
  logic [RAM_WIDTH-1:0]        r_m_data;
  logic                        r_m_valid;
  logic                        r_m_last;
  logic                        w_cmd_load;
  logic                        w_load;
  logic                        w_final_accept;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and datapath strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_cmd_load     = 1'b0;
    w_load         = 1'b0;
    w_final_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            w_state_next = ST_DONE;
          end else begin
            w_cmd_load   = 1'b1;
            w_state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        // A new word may replace the output register when the register is
        // empty or its current word is being taken in this same cycle.
        w_load = (r_remaining != '0) && (!r_m_valid || m_ready);
        // The final word leaves only after every word has been loaded.
        if ((r_remaining == '0) && r_m_valid && m_ready) begin
          w_final_accept = 1'b1;
          w_state_next   = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address pointer, word counter and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
    end else begin
      if (w_cmd_load) begin
        r_ptr       <= base_addr;
        r_remaining <= len;
      end
      if (w_load) begin
        r_m_data    <= ram_dout;
        r_m_valid   <= 1'b1;
        r_m_last    <= (r_remaining == c_LEN_W'(1));
        // The address width sets the RAM depth, so the pointer wraps at the
        // end of the RAM.
        r_ptr       <= r_ptr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end else if (w_final_accept) begin
        r_m_valid   <= 1'b0;
        r_m_last    <= 1'b0;
      end
    end
  end

  assign ram_addr = r_ptr;
  assign m_data   = r_m_data;
  assign m_valid  = r_m_valid;
  assign m_last   = r_m_last;
  assign busy     = (r_state == ST_READ) || (r_state == ST_DONE);
  assign done     = (r_state == ST_DONE);

endmodule : ram_stream_reader
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_stream_reader
// Description : Self-checking bench for ram_stream_reader. A behavioural RAM
//               (write-anywhere array with a combinational read) feeds the
//               reader. A reference model predicts each burst's beats from
//               base, len and the RAM image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_stream_reader;

  localparam int RAM_WIDTH      = 8;
  localparam int RAM_ADDR_WIDTH = 3;
  localparam int DEPTH          = 1 << RAM_ADDR_WIDTH;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] base_addr;
  logic [3:0] len;
  logic       busy;
  logic [2:0] ram_addr;
  logic [7:0] ram_dout;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       done;

  logic [7:0] mem     [DEPTH];
  logic [7:0] ref_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  assign ram_dout = mem[ram_addr];

  ram_stream_reader #(
    .RAM_WIDTH      (RAM_WIDTH),
    .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] base;
    logic [3:0] len;
    int         mode;      // 0: ready high, 1: stall second beat 2 cycles, 2: random
    int         exp_done;  // cycle after start edge where done is high, -1 unchecked
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic ram_write(input int addr, input logic [7:0] val);
    mem[addr % DEPTH]     = val;
    ref_mem[addr % DEPTH] = val;
  endtask

  // Runs one command starting from IDLE, with the caller positioned just after
  // a rising edge. Every accepted beat is compared against the RAM image
  // at address (base + beat index) mod DEPTH.
  task automatic run_burst(input logic [2:0] b, input logic [3:0] l, input int mode,
                           input int exp_done, input int wr_cyc, input logic [7:0] wr_val,
                           input int rs_cyc);
    int         cyc;
    int         beats;
    int         stalls;
    int         done_cyc;
    bit         finished;
    bit         pv;
    bit         pr;
    logic       pl;
    logic [7:0] pd;
    logic [2:0] pa;
    cyc = 0; beats = 0; stalls = 0; done_cyc = -1; finished = 0;
    pv = 0; pr = 0; pl = 0; pd = '0; pa = '0;
    base_addr = b; len = l; start = 1'b1; m_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    while (!finished && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (pv && !pr) begin
        chk("hold_valid", {31'b0, m_valid}, 32'd1);
        chk("hold_data", {24'b0, m_data}, {24'b0, pd});
        chk("hold_last", {31'b0, m_last}, {31'b0, pl});
        chk("hold_ptr", {29'b0, ram_addr}, {29'b0, pa});
      end
      if (l == 4'd0 && m_valid) chk("zero_len_valid", {31'b0, m_valid}, 32'd0);
      if (m_valid && m_ready) begin
        chk("beat_data", {24'b0, m_data}, {24'b0, ref_mem[(int'(b) + beats) % DEPTH]});
        chk("beat_last", {31'b0, m_last}, {31'b0, (beats == int'(l) - 1)});
        beats++;
      end
      if (done) begin
        finished = 1;
        done_cyc = cyc;
        chk("beat_count", beats, int'(l));
        chk("done_valid_low", {31'b0, m_valid}, 32'd0);
      end else begin
        chk("busy_in_burst", {31'b0, busy}, 32'd1);
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last; pa = ram_addr;
      if (!finished) begin
        @(posedge clk);
        #1;
        start = (cyc == rs_cyc);
        if (cyc == rs_cyc) begin
          base_addr = 3'd0;
          len = 4'd1;
        end
        if (cyc == wr_cyc) ram_write(int'(b) + 2, wr_val);
        case (mode)
          1: begin
            if (m_valid && beats == 1 && stalls < 2) begin
              m_ready = 1'b0;
              stalls++;
            end else begin
              m_ready = 1'b1;
            end
          end
          2: m_ready = ($urandom_range(0, 3) != 0);
          default: m_ready = 1'b1;
        endcase
      end
    end
    start = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: got no done expected done within 200 cycles");
    end else if (exp_done >= 0) begin
      chk("done_latency", done_cyc, exp_done);
    end
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("idle_after_done", {31'b0, busy}, 32'd0);
    m_ready = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) ram_write(i, 8'h10 + 8'(i));

    // Reset state
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_last", {31'b0, m_last}, 32'd0);
    chk("rst_addr", {29'b0, ram_addr}, 32'd0);
    chk("rst_data", {24'b0, m_data}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors: basic, wrap, backpressure, zero length, full length
    vecs[0] = '{base: 3'd2, len: 4'd3, mode: 0, exp_done: 5};
    vecs[1] = '{base: 3'd6, len: 4'd4, mode: 0, exp_done: 6};
    vecs[2] = '{base: 3'd1, len: 4'd3, mode: 1, exp_done: 7};
    vecs[3] = '{base: 3'd0, len: 4'd0, mode: 0, exp_done: 1};
    vecs[4] = '{base: 3'd5, len: 4'd8, mode: 0, exp_done: 10};
    vecs[5] = '{base: 3'd3, len: 4'd8, mode: 1, exp_done: 12};
    for (int v = 0; v < 6; v++) begin
      run_burst(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].exp_done, -1, 8'h00, -1);
    end

    // Start re-pulsed mid-burst is ignored; RAM[base+2] rewritten before its load
    run_burst(3'd3, 4'd4, 0, 6, 1, 8'hA5, 1);

    // Asynchronous reset while the second beat is on the output
    base_addr = 3'd1; len = 4'd5; start = 1'b1; m_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", {31'b0, m_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_valid", {31'b0, m_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_last", {31'b0, m_last}, 32'd0);
    chk("abort_data", {24'b0, m_data}, 32'd0);
    chk("abort_addr", {29'b0, ram_addr}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_done", {31'b0, done}, 32'd0);
    chk("rst_hold_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    run_burst(3'd4, 4'd5, 0, 7, -1, 8'h00, -1);

    // Randomised bursts over a random RAM image with random backpressure
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < DEPTH; i++) ram_write(i, 8'($urandom));
      run_burst(3'($urandom_range(0, 7)), 4'($urandom_range(0, 8)), 2, -1, -1, 8'h00, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ram_stream_reader
`default_nettype wire
